spike_time_decoder: RTL and testbench
=====================================

Name: spike_time_decoder

Overview:
- Converts a rising-edge spike on a single temporal-code wire back into a binary arrival time within each gamma cycle.
- Counterpart to the programmable spike delay line, which encodes a binary value as time; this block decodes time to a value.
- Sits at the boundary between the temporal (race-logic) datapath and binary consumers such as readout and classification logic.
- Provides one result per gamma cycle over a valid/ready output port.

Parameters:
- GAMMA_CYCLE_WIDTH, 128: aclk ticks per gamma cycle; power of 2, >= 4.
- PULSE_WIDTH, 8: nominal spike high time in ticks; documentation/assertion only; decode is edge-based.

Ports:
- aclk  in  1  clock.
- grst_n  in  1  synchronous reset, active-low.
- in  in  1  temporal-code spike input, synchronous to aclk.
- out_time  out  $clog2(GAMMA_CYCLE_WIDTH)  arrival phase of the first rising edge in the gamma cycle.
- out_spike  out  1  1 = a spike occurred in the cycle; 0 = no spike ("infinity"), out_time = GAMMA_CYCLE_WIDTH-1.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts the result when high together with out_valid.
- overrun  out  1  one-tick pulse: an unconsumed result was overwritten.
- phase  out  $clog2(GAMMA_CYCLE_WIDTH)  current gamma phase counter, for alignment with other temporal blocks.

Behaviour:
- Reset (grst_n=0 at a posedge aclk): phase=0, in_q=0, state=WAIT, cap_time=0, out_valid=0, out_time=0, out_spike=0, overrun=0. Reset mid-cycle discards the partial capture and any held result.
- Phase counter: phase increments by 1 every tick and wraps from G-1 to 0 with natural power-of-2 wrap.
- Edge detect: rise = in & ~in_q; in_q <= in every tick.
  - in_q is NOT cleared at a cycle boundary. A pulse still high from the previous cycle does not count in the new cycle.
  - in already high on the first tick after reset counts as a rise at phase 0.
- Capture FSM, states WAIT and CAPTURED:
  - WAIT with rise: cap_time <= phase, go to CAPTURED.
  - CAPTURED: further rises are ignored (first-spike-wins).
  - At phase==G-1: both states return to WAIT at the next tick.
- Publish at the tick where phase==G-1; result is registered, so out_valid rises in the tick where phase==0.
  - If CAPTURED: out_time=cap_time, out_spike=1.
  - If WAIT and rise this tick: out_time=G-1, out_spike=1.
  - Otherwise: out_time=G-1, out_spike=0.
- Latency from spike to result: (G-1-arrival phase)+1 ticks.
- Handshake: out_valid is cleared when out_valid & out_ready, unless a publish happens in the same tick. Publish wins: out_valid stays 1 and the new data is loaded.
- Overrun: when publishing while out_valid=1 and out_ready=0, the new result overwrites the held one and overrun=1 for that tick only. A simultaneous accept (out_ready=1) is not an overrun.
- Stability: out_time and out_spike are stable while out_valid=1 and not accepted, except on overrun.
- Delay-line pairing: a spike at phase s through a delay of d yields out_time=s+d when s+d <= G-1. Arrivals at or beyond G fall into the next cycle.

Decomposition:
- Shared temporal package holds:
  - the default GAMMA_CYCLE_WIDTH constant;
  - a function returning the phase width ($clog2);
  - a struct {time, spike} used as the decoded result type by this block and future temporal blocks.
- One natural sub-module: gamma_phase_counter (phase counter plus last-tick strobe), reusable by encoders and delay blocks to share cycle alignment.

Test Plan (G=16 unless noted):
- Reset, then a pulse on in at phase 5 lasting 8 ticks, out_ready=1 -> at phase 0 of the next cycle: out_valid=1, out_time=5, out_spike=1, overrun=0.
- No spike for a full cycle -> out_valid=1, out_time=15, out_spike=0.
- Two rises in one cycle (phases 3 and 9, pulse width 2) -> out_time=3. Pulse rising at phase 14 and held through phase 2 of the next cycle -> that cycle reports 14; the next cycle reports out_spike=0.
- Rise exactly at phase 15 -> out_time=15, out_spike=1. Rise exactly at phase 0 -> out_time=0.
- out_ready=0 for two cycles with spikes at 4 then 7 -> the second publish raises overrun for 1 tick and out_time=7. With out_ready asserted on the publish tick -> no overrun.
- grst_n low for 1 tick at phase 8 after a capture at phase 2 -> all outputs 0, phase restarts at 0, and the next result reflects only post-reset spikes. Pairing check with G=128: an encoder spike at phase 0 through a delay of 37 decodes to 37.

Source files
------------

// File: rtl/spike_time_decoder_pkg.sv
// Shared temporal-code definitions: default gamma length, phase width helper
// and the decoded {time, spike} result type used by temporal blocks.
package spike_time_decoder_pkg;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 128;
    // Widest arrival time any temporal block may report (gamma up to 2**16 ticks).
    localparam int TIME_MAX_W = 16;

    function automatic int phase_width(input int gamma);
        return $clog2(gamma);
    endfunction

    typedef struct packed {
        logic [TIME_MAX_W-1:0] arr_time;
        logic                  spike;
    } decoded_t;

endpackage

// File: rtl/spike_time_decoder_if.sv
// Decoded-result output port: arrival time, spike flag, valid/ready and overrun.
interface spike_time_decoder_if
    import spike_time_decoder_pkg::*;
#(
    parameter int W = phase_width(GAMMA_CYCLE_WIDTH_DEF)
);
    logic [W-1:0] out_time;
    logic         out_spike;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;

    modport master (
        output out_time, out_spike, out_valid, overrun,
        input  out_ready
    );

    modport slave (
        input  out_time, out_spike, out_valid, overrun,
        output out_ready
    );
endinterface

// File: rtl/spike_time_decoder_gamma_phase_counter.sv
// Free-running gamma phase counter with a strobe on the last tick of each cycle;
// shared by temporal encoders, delay lines and decoders to stay cycle-aligned.
module gamma_phase_counter #(
    parameter  int G = 128,
    localparam int W = $clog2(G)
) (
    input  logic         clk,
    input  logic         grst_n,
    output logic [W-1:0] phase,
    output logic         last
);
    // G is a power of 2, so the counter wraps from G-1 to 0 on its own.
    always_ff @(posedge clk) begin
        if (!grst_n) phase <= '0;
        else         phase <= phase + 1'b1;
    end

    assign last = (phase == W'(G - 1));
endmodule

// File: rtl/spike_time_decoder.sv
// Temporal-to-binary decoder: reports the phase of the first rising edge on
// `in` within each gamma cycle, published once per cycle over valid/ready.
module spike_time_decoder
    import spike_time_decoder_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter  int PULSE_WIDTH       = 8,
    localparam int W                 = phase_width(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 aclk,
    input  logic                 grst_n,
    input  logic                 in,
    output logic [W-1:0]         phase,
    spike_time_decoder_if.master res
);
    localparam logic [0:0]   S_WAIT     = 1'b0;
    localparam logic [0:0]   S_CAPTURED = 1'b1;
    localparam logic [W-1:0] LAST_PHASE = W'(GAMMA_CYCLE_WIDTH - 1);

    if (GAMMA_CYCLE_WIDTH < 4 || (GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0) begin : g_bad_gamma
        $error("GAMMA_CYCLE_WIDTH must be a power of 2 and >= 4");
    end
    if (PULSE_WIDTH < 1 || PULSE_WIDTH >= GAMMA_CYCLE_WIDTH) begin : g_bad_pulse
        $error("PULSE_WIDTH must be between 1 and GAMMA_CYCLE_WIDTH-1");
    end

    logic         last;
    logic         in_q;
    logic         rise;
    logic [0:0]   state;
    logic [W-1:0] cap_time;

    gamma_phase_counter #(.G(GAMMA_CYCLE_WIDTH)) u_phase (
        .clk    (aclk),
        .grst_n (grst_n),
        .phase  (phase),
        .last   (last)
    );

    // in_q deliberately survives the cycle boundary so a pulse straddling it
    // is not seen as a fresh spike in the new cycle.
    assign rise = in & ~in_q;

    always_ff @(posedge aclk) begin
        if (!grst_n) begin
            in_q     <= 1'b0;
            state    <= S_WAIT;
            cap_time <= '0;
        end else begin
            in_q <= in;
            if (last) begin
                state <= S_WAIT;
            end else if (state == S_WAIT && rise) begin
                state    <= S_CAPTURED;
                cap_time <= phase;
            end
        end
    end

    // Publish on the last tick; a publish overrides a same-tick accept.
    always_ff @(posedge aclk) begin
        if (!grst_n) begin
            res.out_valid <= 1'b0;
            res.out_time  <= '0;
            res.out_spike <= 1'b0;
            res.overrun   <= 1'b0;
        end else begin
            res.overrun <= 1'b0;
            if (last) begin
                res.out_valid <= 1'b1;
                res.overrun   <= res.out_valid & ~res.out_ready;
                if (state == S_CAPTURED) begin
                    res.out_time  <= cap_time;
                    res.out_spike <= 1'b1;
                end else begin
                    // A rise on the final tick decodes to G-1, same as "no spike"
                    // but flagged as a real arrival.
                    res.out_time  <= LAST_PHASE;
                    res.out_spike <= rise;
                end
            end else if (res.out_valid && res.out_ready) begin
                res.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spike_time_decoder.sv
// Directed bench for spike_time_decoder: per-cycle input patterns, a scoreboard
// of expected decodes, and a G=128 instance for the delay-line pairing case.
module tb_spike_time_decoder;
    import spike_time_decoder_pkg::*;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic       grst_n;
    logic       rst128_n;
    logic       in16;
    logic       in128;
    logic [3:0] phase16;
    logic [6:0] phase128;

    spike_time_decoder_if #(.W(4)) if16 ();
    spike_time_decoder_if #(.W(7)) if128 ();

    spike_time_decoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8)) u_dut16 (
        .aclk   (aclk),
        .grst_n (grst_n),
        .in     (in16),
        .phase  (phase16),
        .res    (if16)
    );

    spike_time_decoder #(.GAMMA_CYCLE_WIDTH(128), .PULSE_WIDTH(8)) u_dut128 (
        .aclk   (aclk),
        .grst_n (rst128_n),
        .in     (in128),
        .phase  (phase128),
        .res    (if128)
    );

    int         checks   = 0;
    int         failures = 0;
    decoded_t   sb[$];
    logic       model_inq   = 1'b0;
    logic       have_result = 1'b0;
    logic [3:0] last_time   = 4'd0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode of one G=16 cycle given the input level before it.
    function automatic decoded_t model(input logic [15:0] pat, input logic prev);
        decoded_t r;
        logic     q;
        r.arr_time = 16'd15;
        r.spike    = 1'b0;
        q          = prev;
        for (int p = 0; p < 16; p++) begin
            if (pat[p] && !q && !r.spike) begin
                r.arr_time = 16'(p);
                r.spike    = 1'b1;
            end
            q = pat[p];
        end
        return r;
    endfunction

    task automatic run_cycle(input string tag, input logic [15:0] pat,
                             input logic rdy0, input logic rdy_mid, input logic rdy_last);
        decoded_t e;
        logic     held;
        logic     exp_ovr;
        sb.push_back(model(pat, model_inq));
        held    = have_result & ~rdy0 & ~rdy_mid;
        exp_ovr = held & ~rdy_last;
        for (int p = 0; p < 16; p++) begin
            in16 = pat[p];
            if16.out_ready = (p == 0) ? rdy0 : ((p == 15) ? rdy_last : rdy_mid);
            check({tag, ".phase"}, 32'(phase16), 32'(p));
            if (p == 1) check({tag, ".ovr_pulse"}, 32'(if16.overrun), 32'd0);
            if (p == 8) begin
                check({tag, ".hold_valid"}, 32'(if16.out_valid), 32'(held));
                if (held) check({tag, ".hold_time"}, 32'(if16.out_time), 32'(last_time));
            end
            tick();
        end
        model_inq = pat[15];
        check({tag, ".valid"}, 32'(if16.out_valid), 32'd1);
        check({tag, ".sb_size"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".time"}, 32'(if16.out_time), 32'(e.arr_time[3:0]));
            check({tag, ".spike"}, 32'(if16.out_spike), 32'(e.spike));
            check({tag, ".overrun"}, 32'(if16.overrun), 32'(exp_ovr));
            last_time = e.arr_time[3:0];
        end
        have_result = 1'b1;
    endtask

    initial begin
        decoded_t e;
        grst_n = 1'b0;
        rst128_n = 1'b0;
        in16 = 1'b0;
        in128 = 1'b0;
        if16.out_ready = 1'b1;
        if128.out_ready = 1'b1;
        tick();
        tick();
        grst_n = 1'b1;

        check("rst.phase", 32'(phase16), 32'd0);
        check("rst.valid", 32'(if16.out_valid), 32'd0);
        check("rst.time", 32'(if16.out_time), 32'd0);
        check("rst.spike", 32'(if16.out_spike), 32'd0);
        check("rst.overrun", 32'(if16.overrun), 32'd0);

        run_cycle("pulse5", 16'h1FE0, 1'b1, 1'b1, 1'b1);
        run_cycle("nospike", 16'h0000, 1'b1, 1'b1, 1'b1);
        run_cycle("two_rise", 16'h0618, 1'b1, 1'b1, 1'b1);
        run_cycle("straddle_a", 16'hC000, 1'b1, 1'b1, 1'b1);
        run_cycle("straddle_b", 16'h0007, 1'b1, 1'b1, 1'b1);
        run_cycle("rise15", 16'h8000, 1'b1, 1'b1, 1'b1);
        run_cycle("low", 16'h0000, 1'b1, 1'b1, 1'b1);
        run_cycle("rise0", 16'h0001, 1'b1, 1'b1, 1'b1);
        run_cycle("hold4", 16'h0010, 1'b1, 1'b0, 1'b0);
        run_cycle("ovr7", 16'h0080, 1'b0, 1'b0, 1'b0);
        run_cycle("accept_pub", 16'h0000, 1'b0, 1'b0, 1'b1);

        // Capture at phase 2, then reset at phase 8: the capture must vanish.
        for (int p = 0; p < 8; p++) begin
            in16 = (p == 2);
            if16.out_ready = 1'b1;
            tick();
        end
        check("mid.phase8", 32'(phase16), 32'd8);
        in16 = 1'b0;
        grst_n = 1'b0;
        tick();
        grst_n = 1'b1;
        check("mid.phase", 32'(phase16), 32'd0);
        check("mid.valid", 32'(if16.out_valid), 32'd0);
        check("mid.time", 32'(if16.out_time), 32'd0);
        check("mid.spike", 32'(if16.out_spike), 32'd0);
        check("mid.overrun", 32'(if16.overrun), 32'd0);
        model_inq = 1'b0;
        have_result = 1'b0;
        run_cycle("post_rst", 16'h0000, 1'b1, 1'b1, 1'b1);

        // Encoder spike at phase 0 through a 37-tick delay, G=128.
        rst128_n = 1'b0;
        tick();
        rst128_n = 1'b1;
        e.arr_time = 16'd37;
        e.spike = 1'b1;
        sb.push_back(e);
        for (int p = 0; p < 128; p++) begin
            in128 = (p >= 37 && p < 45);
            if (p == 0 || p == 127) check("pair.phase", 32'(phase128), 32'(p));
            tick();
        end
        check("pair.valid", 32'(if128.out_valid), 32'd1);
        check("pair.sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pair.time", 32'(if128.out_time), 32'(e.arr_time[6:0]));
            check("pair.spike", 32'(if128.out_spike), 32'(e.spike));
        end
        check("pair.overrun", 32'(if128.overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
